fp_reduce_ctrl: RTL and testbench

Segment-reduction controller that sits directly around the 2-cycle pipelined FP32 adder. It accepts a valid/ready stream of FP32 values delimited by a `last` flag. It feeds operand pairs (incoming value, running sum) to the adder and captures the adder result back into its accumulator. When a segment closes, it presents one FP32 sum plus an element count on a valid/ready output.

---
 rtl/fp_reduce_ctrl.sv | 130 +++++++++++++
 tb/tb_fp_reduce_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_reduce_ctrl.sv
// Segment-reduction controller wrapped around a pipelined FP32 adder.
// Optional feature: define FP_REDUCE_SKIP_ZERO_EN to bypass the adder for zero-exponent elements.
module fp_reduce_ctrl #(
    parameter int ADD_LAT = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_value,
    input  logic               in_last,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_sum,
    output logic [COUNT_W-1:0] out_count
);

    // state | meaning
    // IDLE  | no segment open, next element starts one
    // ACCUM | segment open, waiting for the next element
    // BUSY  | element issued to the adder, waiting for its result
    // OUT   | segment sum presented, waiting for the consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BUSY  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int WCNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

    state_t             state, state_nxt;
    logic [31:0]        acc, acc_nxt;
    logic [COUNT_W-1:0] count, count_nxt, count_inc;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic               pend_last, pend_nxt;
    logic [31:0]        add_a_q, add_a_nxt;
    logic [31:0]        add_b_q, add_b_nxt;
    logic               skip;

`ifdef FP_REDUCE_SKIP_ZERO_EN
    assign skip = (in_value[30:23] == 8'd0);
`else
    assign skip = 1'b0;
`endif

    // Element count saturates instead of wrapping; the sum keeps accumulating.
    assign count_inc = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            wcnt      <= '0;
            pend_last <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            wcnt      <= wcnt_nxt;
            pend_last <= pend_nxt;
            add_a_q   <= add_a_nxt;
            add_b_q   <= add_b_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        wcnt_nxt  = wcnt;
        pend_nxt  = pend_last;
        add_a_nxt = add_a_q;
        add_b_nxt = add_b_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt   = in_value;
                    count_nxt = COUNT_W'(1);
                    state_nxt = in_last ? OUT : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_nxt = count_inc;
                    if (skip) begin
                        state_nxt = in_last ? OUT : ACCUM;
                    end else begin
                        add_a_nxt = in_value;
                        add_b_nxt = acc;
                        pend_nxt  = in_last;
                        wcnt_nxt  = WCNT_W'(ADD_LAT);
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // wcnt reaching zero means add_sum now holds the issued pair's result.
                if (wcnt != '0) begin
                    wcnt_nxt = wcnt - 1'b1;
                end else begin
                    acc_nxt   = add_sum;
                    state_nxt = pend_last ? OUT : ACCUM;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_sum   = acc;
    assign out_count = count;

endmodule

// File: tb/tb_fp_reduce_ctrl.sv
// Bench for fp_reduce_ctrl: 2-cycle adder model, timing/value reference model, random and directed segments.
module tb_fp_reduce_ctrl;
    localparam int ADD_LAT = 2;
    localparam int CW      = 3;
    localparam int MAXC    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_value = '0;
    logic          in_last = 1'b0;
    logic [31:0]   add_a, add_b;
    logic [31:0]   add_sum;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_count;

    fp_reduce_ctrl #(.ADD_LAT(ADD_LAT), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Positive-only FP32 add with truncation; zero-exponent operands count as zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, et;
        logic [24:0] ma, mb, mt, s;
        int          d;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
        if (b[30:23] == 8'd0) return a;
        ea = a[30:23]; ma = {2'b01, a[22:0]};
        eb = b[30:23]; mb = {2'b01, b[22:0]};
        if (ea < eb) begin
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        d = int'(ea) - int'(eb);
        mb = (d > 24) ? 25'd0 : (mb >> d);
        s = ma + mb;
        if (s[24]) begin
            s  = s >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, s[22:0]};
    endfunction

    // Adder pipeline: input flops, then output flop.
    logic [31:0] s_a, s_b, sum_q;
    always @(posedge clk) begin
        if (!rst) begin
            s_a <= '0; s_b <= '0; sum_q <= '0;
        end else begin
            s_a <= add_a; s_b <= add_b;
            sum_q <= fp_add(s_a, s_b);
        end
    end
    assign add_sum = sum_q;

    // Reference model in terms of cycle numbers: when input is allowed, when output is due.
    int          cyc = 0;
    bit          m_open = 0, m_pend = 0;
    int          m_ready_from = 0, m_out_from = 0;
    logic [31:0] m_acc = '0, m_add_a = '0, m_add_b = '0;
    int          m_cnt = 0;
    logic [31:0] last_sum = '0;
    int          last_cnt = 0;
    int          n_seg = 0;

    always @(posedge clk) begin
        bit acc_ok, hs, skip;
        int n, done;
        acc_ok = !m_pend && (cyc >= m_ready_from);
        hs     = m_pend && (cyc >= m_out_from) && out_ready;
        cyc++;
        n = cyc;
        if (!rst) begin
            m_open = 0; m_pend = 0; m_ready_from = 0;
            m_acc = '0; m_cnt = 0; m_add_a = '0; m_add_b = '0;
        end else begin
            if (acc_ok && in_valid) begin
                if (!m_open) begin
                    m_acc = in_value; m_cnt = 1; m_ready_from = n;
                    if (in_last) begin m_pend = 1; m_out_from = n; end
                    else m_open = 1;
                end else begin
                    m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
`ifdef FP_REDUCE_SKIP_ZERO_EN
                    skip = (in_value[30:23] == 8'd0);
`else
                    skip = 0;
`endif
                    done = skip ? n : n + ADD_LAT + 1;
                    if (!skip) begin
                        m_add_a = in_value; m_add_b = m_acc;
                        m_acc = fp_add(in_value, m_acc);
                    end
                    m_ready_from = done;
                    if (in_last) begin m_open = 0; m_pend = 1; m_out_from = done; end
                end
            end
            if (hs) begin
                m_pend = 0; m_ready_from = n;
                last_sum = m_acc; last_cnt = m_cnt; n_seg++;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        bit exp_ov;
        if (chk_en) begin
            exp_ov = m_pend && (cyc >= m_out_from);
            chk("in_ready", 32'(in_ready), 32'(!m_pend && (cyc >= m_ready_from)));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("add_a", add_a, m_add_a);
            chk("add_b", add_b, m_add_b);
            if (exp_ov) begin
                chk("out_sum", out_sum, m_acc);
                chk("out_count", 32'(out_count), 32'(m_cnt));
            end
        end
    end

    // out_ready policy: 0 = always 1, 1 = random, 2 = held low
    int or_mode = 0;
    initial begin
        forever begin
            @(negedge clk);
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    logic [31:0] tx_q[$];
    bit          tx_gaps = 0;

    task automatic send_seg();
        int w;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (tx_gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_value = tx_q[i];
            in_last  = (i == tx_q.size() - 1);
            w = 0;
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_seg(input int prev);
        int w = 0;
        while (n_seg <= prev && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (n_seg <= prev) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: no segment output after %0d cycles, required 1", w);
        end
    endtask

    initial begin
        int p;
        int len;
        logic [31:0] v, a_before;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single element
        p = n_seg; tx_q = '{32'h3F800000}; send_seg();
        chk("single_valid_next_cycle", 32'(out_valid), 32'd1);
        wait_seg(p);
        chk("single_sum", last_sum, 32'h3F800000);
        chk("single_cnt", 32'(last_cnt), 32'd1);

        // 1.0 + 2.0: operands visible right after the second accept
        p = n_seg; tx_q = '{32'h3F800000}; tx_q.push_back(32'h40000000); send_seg();
        chk("pair_add_a", add_a, 32'h40000000);
        chk("pair_add_b", add_b, 32'h3F800000);
        wait_seg(p);
        chk("pair_sum", last_sum, 32'h40400000);
        chk("pair_cnt", 32'(last_cnt), 32'd2);

        // Four ones back-to-back
        p = n_seg; tx_q = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}; send_seg();
        wait_seg(p);
        chk("four_sum", last_sum, 32'h40800000);
        chk("four_cnt", 32'(last_cnt), 32'd4);

        // Count saturation: ten ones, count pinned at 7
        p = n_seg; tx_q = {};
        for (int i = 0; i < 10; i++) tx_q.push_back(32'h3F800000);
        send_seg();
        wait_seg(p);
        chk("sat_sum", last_sum, 32'h41200000);
        chk("sat_cnt", 32'(last_cnt), 32'd7);

        // Output held for 5 cycles
        or_mode = 2;
        p = n_seg; tx_q = '{32'h40400000}; send_seg();
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_sum", out_sum, 32'h40400000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        or_mode = 0;
        wait_seg(p);
        chk("hold_release_ready", 32'(in_ready), 32'd1);

        // Reset at E2 of an adder issue
        tx_q = '{32'h3F800000}; tx_q.push_back(32'h40000000);
        in_valid = 1'b1; in_value = 32'h3F800000; in_last = 1'b0;
        @(negedge clk);
        in_value = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_add_a", add_a, 32'd0);
        chk("mid_rst_out_sum", out_sum, 32'd0);
        p = n_seg; tx_q = '{32'h40000000}; send_seg();
        wait_seg(p);
        chk("post_rst_sum", last_sum, 32'h40000000);
        chk("post_rst_cnt", 32'(last_cnt), 32'd1);

`ifdef FP_REDUCE_SKIP_ZERO_EN
        a_before = add_a;
        p = n_seg;
        in_valid = 1'b1; in_value = 32'h3F800000; in_last = 1'b0;
        @(negedge clk);
        in_value = 32'h00000000;
        @(negedge clk);
        chk("skip_add_a_unchanged", add_a, a_before);
        chk("skip_ready_again", 32'(in_ready), 32'd1);
        in_value = 32'h3F800000; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_seg(p);
        chk("skip_sum", last_sum, 32'h40000000);
        chk("skip_cnt", 32'(last_cnt), 32'd3);
`else
        a_before = 32'd0;
`endif

        // Random segments with gaps and random back-pressure
        or_mode = 1;
        tx_gaps = 1;
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(1, 9);
            tx_q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 5) == 0)
                    v = {9'd0, 23'($urandom)};
                else
                    v = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
                tx_q.push_back(v);
            end
            p = n_seg;
            send_seg();
            wait_seg(p);
        end
        or_mode = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
